// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcodes, request kinds, encoder state.
// Imported by the encoder, its packer and the main control decoder.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] KIND_RTYPE = 3'd0;
  localparam logic [2:0] KIND_LW    = 3'd1;
  localparam logic [2:0] KIND_SW    = 3'd2;
  localparam logic [2:0] KIND_BEQ   = 3'd3;
  localparam logic [2:0] KIND_ADDI  = 3'd4;
  localparam logic [2:0] KIND_J     = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } enc_state_t;

  typedef struct packed {
    logic [2:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
  } enc_req_t;

endpackage

// File: rtl/instr_encoder_if.sv
// Request handshake into the encoder: valid/ready plus instruction fields.
// master = loader side (drives request), slave = encoder (drives ready).
interface instr_encoder_if;

  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_kind;
  logic [4:0]  req_rs;
  logic [4:0]  req_rt;
  logic [4:0]  req_rd;
  logic [5:0]  req_funct;
  logic [15:0] req_imm;
  logic [25:0] req_target;

  modport master (
    output req_valid,
    output req_kind,
    output req_rs,
    output req_rt,
    output req_rd,
    output req_funct,
    output req_imm,
    output req_target,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_kind,
    input  req_rs,
    input  req_rt,
    input  req_rd,
    input  req_funct,
    input  req_imm,
    input  req_target,
    output req_ready
  );

endinterface

// File: rtl/instr_pack.sv
// Combinational packer: request kind + fields -> 32-bit MIPS word.
// Ports: req (fields), word (encoded, 0 if illegal), legal (kind 0-5).
module instr_pack
  import mips_pkg::*;
(
  input  enc_req_t    req,
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    word  = '0;
    legal = 1'b1;
    unique case (1'b1)
      req.kind == KIND_RTYPE:
        word = {OP_RTYPE, req.rs, req.rt,
                req.rd, 5'd0, req.funct};
      req.kind == KIND_LW:
        word = {OP_LW, req.rs, req.rt, req.imm};
      req.kind == KIND_SW:
        word = {OP_SW, req.rs, req.rt, req.imm};
      req.kind == KIND_BEQ:
        word = {OP_BEQ, req.rs, req.rt, req.imm};
      req.kind == KIND_ADDI:
        word = {OP_ADDI, req.rs, req.rt, req.imm};
      req.kind == KIND_J:
        word = {OP_J, req.target};
      default:
        legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Sequential instruction encoder: packs requests into MIPS words and
// writes them to consecutive imem addresses, one per cycle.
// Ports: clk, reset (async active-low), start/finish pulses, req
// (handshake interface), imem_we/imem_addr/imem_wd write port,
// count (words since start), done (full), err (sticky illegal kind).
module instr_encoder
  import mips_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  instr_encoder_if.slave    req,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wd,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err
);

  enc_state_t        state;
  enc_state_t        state_nx;
  logic [ADDR_W-1:0] ptr;
  enc_req_t          fields;
  logic [31:0]       word;
  logic              legal;
  logic              acc;
  logic              wr;
  logic              last;
  logic              arm;

  assign fields = '{
    kind:   req.req_kind,
    rs:     req.req_rs,
    rt:     req.req_rt,
    rd:     req.req_rd,
    funct:  req.req_funct,
    imm:    req.req_imm,
    target: req.req_target
  };

  instr_pack u_pack (
    .req   (fields),
    .word  (word),
    .legal (legal)
  );

  assign req.req_ready = (state == ST_RUN);
  assign acc  = req.req_valid & req.req_ready;
  assign wr   = acc & legal;
  // pointer all-ones is the last writable word
  assign last = &ptr;
  // start only re-arms from IDLE or FULL
  assign arm  = start & (state != ST_RUN);
  assign done = (state == ST_FULL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (finish) begin
          state_nx = ST_IDLE;
        end else if (wr && last) begin
          state_nx = ST_FULL;
        end
      end
      ST_FULL: begin
        if (start) state_nx = ST_RUN;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr       <= '0;
      count     <= '0;
      err       <= 1'b0;
      imem_we   <= 1'b0;
      imem_addr <= '0;
      imem_wd   <= '0;
    end else begin
      imem_we <= 1'b0;
      if (arm) begin
        ptr   <= '0;
        count <= '0;
        err   <= 1'b0;
      end else if (wr) begin
        imem_we   <= 1'b1;
        imem_addr <= ptr;
        imem_wd   <= word;
        ptr       <= ptr + 1'b1;
        count     <= count + 1'b1;
      end else if (acc) begin
        // illegal kind: consumed, nothing written
        err <= 1'b1;
      end
    end
  end

endmodule
